// File: rtl/scaler_param_sched.sv
// Frame-synchronous parameter scheduler: single-step commands edit shadow registers, committed at frame start.
// Optional frame_cnt / pending_frames outputs are enabled with `define SCALER_PARAM_SCHED_FRAMECNT_EN.
module scaler_param_sched #(
    parameter int W_MAX       = 62,
    parameter int H_MAX       = 71,
    parameter int PY_MAX      = 36,
    parameter int PX_MAX      = 64,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        pixclk_in,
    input  logic        rst_i,
    input  logic        vs_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic        cmd_dir,
    output logic [5:0]  scaler_ctrl_width,
    output logic [6:0]  scaler_ctrl_height,
    output logic [5:0]  panning_y_ctrl,
    output logic [6:0]  panning_x_ctrl,
    output logic        color_reverse_ctrl,
    output logic        commit_pulse,
    output logic        busy
`ifdef SCALER_PARAM_SCHED_FRAMECNT_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [7:0]  pending_frames
`endif
);

    localparam logic [5:0] W_LIM  = 6'(W_MAX);
    localparam logic [6:0] H_LIM  = 7'(H_MAX);
    localparam logic [5:0] PY_LIM = 6'(PY_MAX);
    localparam logic [6:0] PX_LIM = 7'(PX_MAX);
    localparam int         HCW    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT, HOLD} state_t;

    typedef struct packed {
        logic       color;
        logic [6:0] pan_x;
        logic [5:0] pan_y;
        logic [6:0] height;
        logic [5:0] width;
    } params_t;

    state_t         state, state_next;
    params_t        shadow, shadow_next, active;
    logic           vs_in_1d;
    logic           frame_start;
    logic           accept;
    logic           commit;
    logic [HCW-1:0] hold_cnt;
    logic [6:0]     h_up, h_dn;

    assign frame_start = vs_in & ~vs_in_1d;
    // NOTE: cmd_ready/busy decode the state register directly, so an async reset forces them at once.
    assign cmd_ready   = (state == IDLE) || (state == PENDING);
    assign busy        = (state != IDLE);
    assign accept      = cmd_valid & cmd_ready;
    assign commit      = (state == PENDING) && frame_start;

    // Height skips the illegal codes 25 and 45 in both directions.
    always_comb begin
        h_up = shadow.height + 7'd1;
        if (h_up == 7'd25 || h_up == 7'd45) h_up = h_up + 7'd1;
        h_dn = shadow.height - 7'd1;
        if (h_dn == 7'd25 || h_dn == 7'd45) h_dn = h_dn - 7'd1;
    end

    always_comb begin
        shadow_next = shadow;
        if (accept) begin
            case (cmd_op)
                3'd0: if (cmd_dir) begin
                          if (shadow.width < W_LIM) shadow_next.width = shadow.width + 6'd1;
                      end else if (shadow.width != 6'd0) shadow_next.width = shadow.width - 6'd1;
                3'd1: if (cmd_dir) begin
                          if (shadow.height < H_LIM && h_up <= H_LIM) shadow_next.height = h_up;
                      end else if (shadow.height != 7'd0) shadow_next.height = h_dn;
                3'd2: if (cmd_dir) begin
                          if (shadow.pan_y < PY_LIM) shadow_next.pan_y = shadow.pan_y + 6'd1;
                      end else if (shadow.pan_y != 6'd0) shadow_next.pan_y = shadow.pan_y - 6'd1;
                3'd3: if (cmd_dir) begin
                          if (shadow.pan_x < PX_LIM) shadow_next.pan_x = shadow.pan_x + 7'd1;
                      end else if (shadow.pan_x != 7'd0) shadow_next.pan_x = shadow.pan_x - 7'd1;
                3'd4: shadow_next.color = ~shadow.color;
                3'd5: shadow_next = '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (shadow_next != active) state_next = PENDING;
            PENDING: if (frame_start) state_next = COMMIT;
                     else if (shadow_next == active) state_next = IDLE;
            COMMIT:  state_next = HOLD;
            HOLD:    if (hold_cnt == HOLD_LAST) state_next = (shadow != active) ? PENDING : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pixclk_in or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // The commit copies the pre-update shadow, so a command in the frame-start cycle waits a frame.
    always_ff @(posedge pixclk_in or posedge rst_i) begin
        if (rst_i) begin
            shadow       <= '0;
            active       <= '0;
            commit_pulse <= 1'b0;
            vs_in_1d     <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            shadow       <= shadow_next;
            commit_pulse <= commit;
            vs_in_1d     <= vs_in;
            if (commit) active <= shadow;
            hold_cnt     <= (state == HOLD) ? hold_cnt + HCW'(1) : '0;
        end
    end

    assign scaler_ctrl_width  = active.width;
    assign scaler_ctrl_height = active.height;
    assign panning_y_ctrl     = active.pan_y;
    assign panning_x_ctrl     = active.pan_x;
    assign color_reverse_ctrl = active.color;

`ifdef SCALER_PARAM_SCHED_FRAMECNT_EN
    always_ff @(posedge pixclk_in or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt      <= '0;
            pending_frames <= '0;
        end else begin
            if (frame_start) frame_cnt <= frame_cnt + 16'd1;
            if (commit)
                pending_frames <= '0;
            else if (frame_start && state == HOLD && shadow != active && pending_frames != 8'hFF)
                pending_frames <= pending_frames + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scaler_param_sched.sv
// Self-checking bench for scaler_param_sched: directed test-plan scenarios plus randomized traffic vs a behavioural model.
module tb_scaler_param_sched;

    localparam int W_MAX = 62, H_MAX = 71, PY_MAX = 36, PX_MAX = 64, HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs_in, cmd_valid, cmd_dir;
    logic [2:0] cmd_op;
    logic       cmd_ready, color, pulse, busy;
    logic [5:0] width, pan_y;
    logic [6:0] height, pan_x;
`ifdef SCALER_PARAM_SCHED_FRAMECNT_EN
    logic [15:0] frame_cnt;
    logic [7:0]  pending_frames;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scaler_param_sched dut (
        .pixclk_in          (clk),
        .rst_i              (rst),
        .vs_in              (vs_in),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_dir            (cmd_dir),
        .scaler_ctrl_width  (width),
        .scaler_ctrl_height (height),
        .panning_y_ctrl     (pan_y),
        .panning_x_ctrl     (pan_x),
        .color_reverse_ctrl (color),
        .commit_pulse       (pulse),
        .busy               (busy)
`ifdef SCALER_PARAM_SCHED_FRAMECNT_EN
        ,
        .frame_cnt          (frame_cnt),
        .pending_frames     (pending_frames)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: shadow/active values plus a lockout countdown after each commit.
    typedef struct {
        int w, h, py, px, c;
        int aw, ah, apy, apx, ac;
        int lock;
        int pulse;
        int vs_prev;
        int fcnt, pfr;
    } model_t;

    model_t m;

    function automatic bit h_legal(input int v);
        return v != 25 && v != 45;
    endfunction

    function automatic int h_step(input int h, input bit up);
        if (up) begin
            for (int v = h + 1; v <= H_MAX; v++) if (h_legal(v)) return v;
        end else begin
            for (int v = h - 1; v >= 0; v--) if (h_legal(v)) return v;
        end
        return h;
    endfunction

    function automatic int sat(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    function automatic bit differs(input model_t s);
        return s.w != s.aw || s.h != s.ah || s.py != s.apy || s.px != s.apx || s.c != s.ac;
    endfunction

    function automatic model_t model_next(input model_t s, input bit vs, input bit valid,
                                          input int op, input bit dir);
        model_t n = s;
        bit ready = (s.lock == 0);
        bit fs = vs && (s.vs_prev == 0);
        bit cm = ready && fs && differs(s);
        int d = dir ? 1 : -1;
        if (fs) n.fcnt = (s.fcnt + 1) % 65536;
        if (cm) n.pfr = 0;
        else if (fs && s.lock > 0 && s.lock <= HOLD && differs(s) && s.pfr < 255) n.pfr = s.pfr + 1;
        if (cm) begin
            n.aw = s.w; n.ah = s.h; n.apy = s.py; n.apx = s.px; n.ac = s.c;
            n.pulse = 1;
            n.lock = HOLD + 1;
        end else begin
            n.pulse = 0;
            if (s.lock > 0) n.lock = s.lock - 1;
        end
        if (valid && ready) begin
            case (op)
                0: n.w  = sat(s.w + d, W_MAX);
                1: n.h  = h_step(s.h, dir);
                2: n.py = sat(s.py + d, PY_MAX);
                3: n.px = sat(s.px + d, PX_MAX);
                4: n.c  = 1 - s.c;
                5: begin n.w = 0; n.h = 0; n.py = 0; n.px = 0; n.c = 0; end
                default: ;
            endcase
        end
        n.vs_prev = vs;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{default: 0};
        else     m <= model_next(m, vs_in, cmd_valid, int'(cmd_op), cmd_dir);
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check("width",     width,     m.aw);
        check("height",    height,    m.ah);
        check("pan_y",     pan_y,     m.apy);
        check("pan_x",     pan_x,     m.apx);
        check("color",     color,     m.ac);
        check("pulse",     pulse,     m.pulse);
        check("cmd_ready", cmd_ready, (m.lock == 0) ? 1 : 0);
        check("busy",      busy,      (m.lock > 0 || differs(m)) ? 1 : 0);
`ifdef SCALER_PARAM_SCHED_FRAMECNT_EN
        check("frame_cnt",      frame_cnt,      m.fcnt);
        check("pending_frames", pending_frames, m.pfr);
`endif
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input int op, input bit dir);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_dir   = dir;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic frame_rise();
        vs_in = 1'b1;
        @(negedge clk);
        vs_in = 1'b0;
    endtask

    initial begin
        int low;
        int cnt;
        bit bias;
        rst = 1'b1; vs_in = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_dir = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_width", width, 0);
        check("reset_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Three width increments, commit one cycle after vs sampled high, then lockout.
        repeat (3) send(0, 1'b1);
        check("pend_busy", busy, 1);
        check("pend_width_held", width, 0);
        frame_rise();
        check("w3_width", width, 3);
        check("w3_pulse", pulse, 1);
        check("w3_ready", cmd_ready, 0);
        @(negedge clk);
        check("w3_pulse_drop", pulse, 0);
        low = 1;
        while (!cmd_ready && low < 40) begin
            low++;
            @(negedge clk);
        end
        check("w3_ready_low_cycles", low, 1 + HOLD);

        // Async reset in the middle of HOLD with width 10 active.
        repeat (7) send(0, 1'b1);
        frame_rise();
        check("w10_width", width, 10);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_width", width, 0);
        check("async_rst_ready", cmd_ready, 1);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Height skips 25 and 45 and saturates at 71.
        repeat (24) send(1, 1'b1);
        frame_rise();
        check("h24", height, 24);
        send(1, 1'b1);
        frame_rise();
        check("h24_up", height, 26);
        repeat (19) send(1, 1'b1);
        frame_rise();
        check("h46", height, 46);
        send(1, 1'b0);
        frame_rise();
        check("h46_down", height, 44);
        repeat (27) send(1, 1'b1);
        frame_rise();
        check("h_max", height, 71);
        send(1, 1'b1);
        check("h_sat_idle", busy, 0);

        // Pan-x decrement at 0 and pan-y increment at 36 change nothing.
        send(3, 1'b0);
        check("px0_idle", busy, 0);
        frame_rise();
        check("px0_no_commit", pulse, 0);
        repeat (37) send(2, 1'b1);
        frame_rise();
        check("py_max", pan_y, 36);
        send(2, 1'b1);
        check("py_sat_idle", busy, 0);

        // Command accepted in the frame-start cycle lands one frame later.
        repeat (5) send(3, 1'b1);
        vs_in = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd3; cmd_dir = 1'b1;
        @(negedge clk);
        vs_in = 1'b0; cmd_valid = 1'b0;
        check("vs_cmd_px", pan_x, 5);
        check("vs_cmd_pulse", pulse, 1);
        wait_ready();
        check("vs_cmd_pending", busy, 1);
        check("vs_cmd_px_held", pan_x, 5);
        frame_rise();
        check("vs_cmd_px_next", pan_x, 6);

        // Double colour toggle returns to IDLE without a commit.
        send(4, 1'b0);
        send(4, 1'b0);
        check("color_idle", busy, 0);
        frame_rise();
        check("color_no_commit", pulse, 0);
        check("color_val", color, 0);

        // Randomized traffic with drifting direction bias and irregular frames.
        cnt = 10; bias = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) bias = ~bias;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 3'($urandom_range(0, 7));
            if (cmd_op == 3'd5 && $urandom_range(0, 3) != 0) cmd_op = 3'd0;
            cmd_dir   = ($urandom_range(0, 3) != 0) ? bias : ~bias;
            vs_in     = (cnt < 3);
            if (cnt == 0) cnt = $urandom_range(8, 60);
            else cnt--;
            rst = (i == 2000);
            @(negedge clk);
        end
        rst = 1'b0; cmd_valid = 1'b0; vs_in = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
